// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback stage.
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_SRL = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_EQ  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } exec_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear of every entry.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 4,
    localparam int IDX_W = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddrA_i,
    output logic [DATA_W-1:0] rdataA_o,
    input  logic [IDX_W-1:0]  raddrB_i,
    output logic [DATA_W-1:0] rdataB_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o = regs_q[raddrA_i];
    assign rdataB_o = regs_q[raddrB_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback stage around an external combinational 8-bit ALU:
// accept, drive registered operands, capture result, write back, hand off.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int CNT_W    = 16,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [2:0]        instr_op_i,
    input  logic [IDX_W-1:0]  instr_rd_i,
    input  logic [IDX_W-1:0]  instr_rs1_i,
    input  logic [IDX_W-1:0]  instr_rs2_i,
    input  logic              instr_imm_en_i,
    input  logic [DATA_W-1:0] instr_imm_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic [IDX_W-1:0]  res_rd_o,
    output logic [CNT_W-1:0]  op_count_o
);

    exec_state_e       state_q, state_d;
    logic [DATA_W-1:0] aluA_q, aluA_d;
    logic [DATA_W-1:0] aluB_q, aluB_d;
    logic [2:0]        aluOp_q, aluOp_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] resData_q, resData_d;
    logic [CNT_W-1:0]  opCount_q, opCount_d;

    logic [DATA_W-1:0] rdataA;
    logic [DATA_W-1:0] rdataB;
    logic              regWe;

    // Writeback lands at the end of EXEC so the next accepted instruction
    // always sees the new value without any forwarding path.
    assign regWe = (state_q == EXEC);

    alu_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (regWe),
        .waddr_i  (rd_q),
        .wdata_i  (alu_res_i),
        .raddrA_i (instr_rs1_i),
        .rdataA_o (rdataA),
        .raddrB_i (instr_rs2_i),
        .rdataB_o (rdataB)
    );

    always_comb begin
        state_d   = state_q;
        aluA_d    = aluA_q;
        aluB_d    = aluB_q;
        aluOp_d   = aluOp_q;
        rd_d      = rd_q;
        resData_d = resData_q;
        opCount_d = opCount_q;
        case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    aluA_d  = rdataA;
                    aluB_d  = instr_imm_en_i ? instr_imm_i : rdataB;
                    aluOp_d = instr_op_i;
                    rd_d    = instr_rd_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resData_d = alu_res_i;
                state_d   = RESP;
            end
            RESP: begin
                if (res_ready_i) begin
                    opCount_d = opCount_q + CNT_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aluA_q    <= '0;
            aluB_q    <= '0;
            aluOp_q   <= '0;
            rd_q      <= '0;
            resData_q <= '0;
            opCount_q <= '0;
        end else begin
            state_q   <= state_d;
            aluA_q    <= aluA_d;
            aluB_q    <= aluB_d;
            aluOp_q   <= aluOp_d;
            rd_q      <= rd_d;
            resData_q <= resData_d;
            opCount_q <= opCount_d;
        end
    end

    assign instr_ready_o = (state_q == IDLE);
    assign res_valid_o   = (state_q == RESP);
    assign alu_a_o       = aluA_q;
    assign alu_b_o       = aluB_q;
    assign alu_op_o      = aluOp_q;
    assign res_data_o    = resData_q;
    assign res_rd_o      = rd_q;
    assign op_count_o    = opCount_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed self-checking bench for alu_exec_ctrl; the bench supplies the ALU.
module tb_alu_exec_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [2:0]  instr_op_i = '0;
    logic [1:0]  instr_rd_i = '0;
    logic [1:0]  instr_rs1_i = '0;
    logic [1:0]  instr_rs2_i = '0;
    logic        instr_imm_en_i = 1'b0;
    logic [7:0]  instr_imm_i = '0;
    logic [7:0]  alu_a_o;
    logic [7:0]  alu_b_o;
    logic [2:0]  alu_op_o;
    logic [7:0]  alu_res_i;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [7:0]  res_data_o;
    logic [1:0]  res_rd_o;
    logic [15:0] op_count_o;

    int compareCount = 0;
    int failCount = 0;

    always #5 clk_i = ~clk_i;

    // Reference ALU attached alongside the stage, as at the real top level.
    always_comb begin
        alu_res_i = 8'h00;
        case (alu_op_o)
            3'b000: alu_res_i = alu_a_o + alu_b_o;
            3'b001: alu_res_i = alu_a_o - alu_b_o;
            3'b010: alu_res_i = alu_a_o << alu_b_o;
            3'b011: alu_res_i = alu_a_o >> alu_b_o;
            3'b100: alu_res_i = alu_a_o & alu_b_o;
            3'b101: alu_res_i = alu_a_o | alu_b_o;
            3'b110: alu_res_i = alu_a_o ^ alu_b_o;
            default: alu_res_i = (alu_a_o == alu_b_o) ? 8'h01 : 8'h00;
        endcase
    end

    alu_exec_ctrl #(
        .NUM_REGS (4),
        .CNT_W    (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .instr_op_i     (instr_op_i),
        .instr_rd_i     (instr_rd_i),
        .instr_rs1_i    (instr_rs1_i),
        .instr_rs2_i    (instr_rs2_i),
        .instr_imm_en_i (instr_imm_en_i),
        .instr_imm_i    (instr_imm_i),
        .alu_a_o        (alu_a_o),
        .alu_b_o        (alu_b_o),
        .alu_op_o       (alu_op_o),
        .alu_res_i      (alu_res_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_data_o     (res_data_o),
        .res_rd_o       (res_rd_o),
        .op_count_o     (op_count_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one instruction for a single edge; returns #1 after the accept edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd,
                                 input logic [1:0] rs1, input logic [1:0] rs2,
                                 input logic immEn, input logic [7:0] imm);
        @(negedge clk_i);
        instr_op_i     = op;
        instr_rd_i     = rd;
        instr_rs1_i    = rs1;
        instr_rs2_i    = rs2;
        instr_imm_en_i = immEn;
        instr_imm_i    = imm;
        instr_valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        instr_valid_i  = 1'b0;
    endtask

    task automatic doHandshake();
        @(negedge clk_i);
        res_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        res_ready_i = 1'b0;
    endtask

    task automatic runInstr(input string tag, input logic [2:0] op, input logic [1:0] rd,
                            input logic [1:0] rs1, input logic [1:0] rs2,
                            input logic immEn, input logic [7:0] imm,
                            input logic [7:0] expData, input logic [15:0] expCount);
        applyStimulus(op, rd, rs1, rs2, immEn, imm);
        @(posedge clk_i);
        #1;
        checkOutput({tag, "_valid"}, res_valid_o, 1);
        checkOutput({tag, "_data"}, res_data_o, expData);
        checkOutput({tag, "_rd"}, res_rd_o, rd);
        doHandshake();
        checkOutput({tag, "_count"}, op_count_o, expCount);
        checkOutput({tag, "_ready"}, instr_ready_o, 1);
    endtask

    initial begin
        $display("[TB] start");
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_ready", instr_ready_o, 1);
        checkOutput("rst_valid", res_valid_o, 0);
        checkOutput("rst_data", res_data_o, 0);
        checkOutput("rst_rd", res_rd_o, 0);
        checkOutput("rst_count", op_count_o, 0);
        checkOutput("rst_alu_a", alu_a_o, 0);
        checkOutput("rst_alu_b", alu_b_o, 0);
        checkOutput("rst_alu_op", alu_op_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ADD r1 = r0 + 0x05, with timing checks around the accept
        applyStimulus(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
        checkOutput("add1_alu_a", alu_a_o, 8'h00);
        checkOutput("add1_alu_b", alu_b_o, 8'h05);
        checkOutput("add1_alu_op", alu_op_o, 3'b000);
        checkOutput("add1_ready_exec", instr_ready_o, 0);
        checkOutput("add1_valid_exec", res_valid_o, 0);
        @(posedge clk_i);
        #1;
        checkOutput("add1_valid", res_valid_o, 1);
        checkOutput("add1_data", res_data_o, 8'h05);
        checkOutput("add1_rd", res_rd_o, 2'd1);
        checkOutput("add1_count_pre", op_count_o, 0);
        doHandshake();
        checkOutput("add1_count", op_count_o, 1);
        checkOutput("add1_valid_post", res_valid_o, 0);

        runInstr("add2", 3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 8'h03, 8'h03, 16'd2);
        runInstr("sub", 3'b001, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00, 8'hFE, 16'd3);
        runInstr("addwrap", 3'b000, 2'd3, 2'd3, 2'd0, 1'b1, 8'h03, 8'h01, 16'd4);
        runInstr("sll", 3'b010, 2'd2, 2'd1, 2'd0, 1'b1, 8'h03, 8'h28, 16'd5);
        runInstr("xor", 3'b110, 2'd2, 2'd2, 2'd1, 1'b0, 8'h00, 8'h2D, 16'd6);

        // ADD r0 = r1 + 0x10, then stall RESP with a competing instruction offered
        applyStimulus(3'b000, 2'd0, 2'd1, 2'd0, 1'b1, 8'h10);
        @(posedge clk_i);
        #1;
        instr_op_i     = 3'b101;
        instr_rd_i     = 2'd1;
        instr_rs1_i    = 2'd3;
        instr_rs2_i    = 2'd2;
        instr_imm_en_i = 1'b1;
        instr_imm_i    = 8'hAA;
        instr_valid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", res_valid_o, 1);
            checkOutput("stall_data", res_data_o, 8'h15);
            checkOutput("stall_ready", instr_ready_o, 0);
            checkOutput("stall_count", op_count_o, 6);
            checkOutput("stall_alu_b", alu_b_o, 8'h10);
            @(posedge clk_i);
            #1;
        end
        instr_valid_i = 1'b0;
        doHandshake();
        checkOutput("stall_count_post", op_count_o, 7);
        checkOutput("stall_alu_a_post", alu_a_o, 8'h05);

        runInstr("eq_same", 3'b111, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00, 8'h01, 16'd8);
        runInstr("eq_diff", 3'b111, 2'd0, 2'd1, 2'd0, 1'b1, 8'h06, 8'h00, 16'd9);

        // Reset while ADD r1 = r0 + 0x7F sits in EXEC
        applyStimulus(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("midrst_valid", res_valid_o, 0);
        checkOutput("midrst_ready", instr_ready_o, 1);
        checkOutput("midrst_count", op_count_o, 0);
        checkOutput("midrst_data", res_data_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        runInstr("or_after_rst", 3'b101, 2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 8'h00, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
